datapath_seq: RTL and testbench

//  Parametrised successor of the single-issue datapath. Holds the register file, the A/B/C

---
 rtl/datapath_seq.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
// datapath_seq: sequenced single-issue datapath.
//
// Holds the register file, the A/B/C pipeline registers, the B-operand shifter,
// the ALU and the N/V/Z status register. One start pulse in IDLE runs the fixed
// sequence RDA -> RDB -> EXE -> WB. The operation fields are captured on the
// accepted start, so the decoder may change them freely while the block is busy.
//
// Optional feature: define CARRY_FLAG_EN to build the carry flag. When the macro
// is undefined, C_flag is tied low and no carry logic exists. The port is always
// present.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   start             request one operation; only sampled in IDLE
//   op                00 ADD, 01 SUB, 10 AND, 11 MVN
//   shift             B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   rn, rm, rd        A source, B source and destination register indices
//   use_imm, imm      replace the shifted B with sign-extended imm
//   wb_en             write C back to R[rd] in the WB cycle
//   set_flags         load the status flags in the EXE cycle
//   ext_we/waddr/wdata external register write port, honoured only in IDLE
//   busy              high in every state except IDLE
//   done              one-cycle pulse in the WB cycle
//   datapath_out      C register
//   N, V, Z, C_flag   status flags
module datapath_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned RW    = 3,
  parameter int unsigned IMM_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       shift,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic [RW-1:0]    rd,
  input  logic             use_imm,
  input  logic [IMM_W-1:0] imm,
  input  logic             wb_en,
  input  logic             set_flags,
  input  logic             ext_we,
  input  logic [RW-1:0]    ext_waddr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] datapath_out,
  output logic             N,
  output logic             V,
  output logic             Z,
  output logic             C_flag
);

  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpMvn = 2'b11;

  localparam logic [1:0] ShNone = 2'b00;
  localparam logic [1:0] ShLsl  = 2'b01;
  localparam logic [1:0] ShLsr  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StExe,
    StWb
  } state_e;

  // Operation fields captured on the accepted start.
  typedef struct packed {
    logic [1:0]       op;
    logic [1:0]       shift;
    logic [RW-1:0]    rn;
    logic [RW-1:0]    rm;
    logic [RW-1:0]    rd;
    logic             use_imm;
    logic [IMM_W-1:0] imm;
    logic             wb_en;
    logic             set_flags;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic [WIDTH-1:0] b_shifted;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;

  logic in_idle;
  logic in_exe;
  logic load_flags;

  assign in_idle    = (state_q == StIdle);
  assign in_exe     = (state_q == StExe);
  assign load_flags = in_exe && ctrl_q.set_flags;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d = StRdA;
        end
      end
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StExe;
      StExe:   state_d = StWb;
      StWb: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (in_idle && start) begin
      ctrl_d.op        = op;
      ctrl_d.shift     = shift;
      ctrl_d.rn        = rn;
      ctrl_d.rm        = rm;
      ctrl_d.rd        = rd;
      ctrl_d.use_imm   = use_imm;
      ctrl_d.imm       = imm;
      ctrl_d.wb_en     = wb_en;
      ctrl_d.set_flags = set_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file: the external port owns IDLE, write-back owns WB, so the two
  // writers can never collide.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_d = rf_q;
    if (in_idle && ext_we) begin
      rf_d[ext_waddr] = ext_wdata;
    end
    if ((state_q == StWb) && ctrl_q.wb_en) begin
      rf_d[ctrl_q.rd] = c_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand registers and B-operand selection
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (state_q == StRdA) begin
      a_d = rf_q[ctrl_q.rn];
    end
    if (state_q == StRdB) begin
      b_d = rf_q[ctrl_q.rm];
    end
  end

  always_comb begin
    b_shifted = b_q;
    case (ctrl_q.shift)
      ShNone:  b_shifted = b_q;
      ShLsl:   b_shifted = {b_q[Msb-1:0], 1'b0};
      ShLsr:   b_shifted = {1'b0, b_q[Msb:1]};
      default: b_shifted = {b_q[Msb], b_q[Msb:1]};
    endcase
  end

  assign imm_ext = {{(WIDTH - IMM_W){ctrl_q.imm[IMM_W-1]}}, ctrl_q.imm};
  assign bin     = ctrl_q.use_imm ? imm_ext : b_shifted;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
`ifdef CARRY_FLAG_EN
  logic             alu_c;
  logic [WIDTH:0]   alu_wide;
  logic             cf_q, cf_d;

  always_comb begin
    alu_res  = '0;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    alu_wide = '0;
    case (ctrl_q.op)
      OpAdd: begin
        alu_wide = {1'b0, a_q} + {1'b0, bin};
        alu_res  = alu_wide[Msb:0];
        alu_c    = alu_wide[WIDTH];
        alu_v    = (a_q[Msb] == bin[Msb]) && (alu_res[Msb] != a_q[Msb]);
      end
      OpSub: begin
        // Top bit of the widened difference is the borrow; carry means no borrow.
        alu_wide = {1'b0, a_q} - {1'b0, bin};
        alu_res  = alu_wide[Msb:0];
        alu_c    = ~alu_wide[WIDTH];
        alu_v    = (a_q[Msb] != bin[Msb]) && (alu_res[Msb] != a_q[Msb]);
      end
      OpAnd:   alu_res = a_q & bin;
      OpMvn:   alu_res = ~bin;
      default: alu_res = '0;
    endcase
  end

  assign cf_d   = load_flags ? alu_c : cf_q;
  assign C_flag = cf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cf_q <= 1'b0;
    end else begin
      cf_q <= cf_d;
    end
  end
`else
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ctrl_q.op)
      OpAdd: begin
        alu_res = a_q + bin;
        alu_v   = (a_q[Msb] == bin[Msb]) && (alu_res[Msb] != a_q[Msb]);
      end
      OpSub: begin
        alu_res = a_q - bin;
        alu_v   = (a_q[Msb] != bin[Msb]) && (alu_res[Msb] != a_q[Msb]);
      end
      OpAnd:   alu_res = a_q & bin;
      OpMvn:   alu_res = ~bin;
      default: alu_res = '0;
    endcase
  end

  assign C_flag = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Result and status registers
  // ---------------------------------------------------------------------------
  always_comb begin
    c_d = c_q;
    n_d = n_q;
    v_d = v_q;
    z_d = z_q;
    if (in_exe) begin
      c_d = alu_res;
    end
    if (load_flags) begin
      n_d = alu_res[Msb];
      v_d = alu_v;
      z_d = (alu_res == '0);
    end
  end

  assign datapath_out = c_q;
  assign N            = n_q;
  assign V            = v_q;
  assign Z            = z_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: expected results are queued when an operation
// is started and checked by the done-cycle monitor.
module tb_datapath_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  shift;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [2:0]  rd;
  logic        use_imm;
  logic [4:0]  imm;
  logic        wb_en;
  logic        set_flags;
  logic        ext_we;
  logic [2:0]  ext_waddr;
  logic [15:0] ext_wdata;
  logic        busy;
  logic        done;
  logic [15:0] datapath_out;
  logic        N;
  logic        V;
  logic        Z;
  logic        C_flag;

  always #5 clk = ~clk;

  datapath_seq #(
    .WIDTH(16),
    .NREGS(8),
    .RW   (3),
    .IMM_W(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .shift       (shift),
    .rn          (rn),
    .rm          (rm),
    .rd          (rd),
    .use_imm     (use_imm),
    .imm         (imm),
    .wb_en       (wb_en),
    .set_flags   (set_flags),
    .ext_we      (ext_we),
    .ext_waddr   (ext_waddr),
    .ext_wdata   (ext_wdata),
    .busy        (busy),
    .done        (done),
    .datapath_out(datapath_out),
    .N           (N),
    .V           (V),
    .Z           (Z),
    .C_flag      (C_flag)
  );

  typedef struct {
    logic [15:0] c;
    bit          chk_f;
    logic        n;
    logic        v;
    logic        z;
    logic        cf;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp       = 0;
  int   n_err       = 0;
  int   cyc         = 0;
  int   start_cyc   = 0;
  int   busy_cycles = 0;
  int   done_cnt    = 0;
  int   lat_last    = 0;

  function automatic logic cf_exp(input logic v);
`ifdef CARRY_FLAG_EN
    return v;
`else
    return v & 1'b0;
`endif
  endfunction

  function automatic exp_t mk(input logic [15:0] c, input bit f, input logic n, input logic v,
                              input logic z, input logic cf, input string tag);
    exp_t e;
    e.c = c; e.chk_f = f; e.n = n; e.v = v; e.z = z; e.cf = cf; e.tag = tag;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Done-cycle monitor: pops the scoreboard and checks C and the flags.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_out"}, datapath_out, e.c);
        if (e.chk_f) begin
          chk({e.tag, "_N"}, N, e.n);
          chk({e.tag, "_V"}, V, e.v);
          chk({e.tag, "_Z"}, Z, e.z);
          chk({e.tag, "_C"}, C_flag, e.cf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_wr(input logic [2:0] a, input logic [15:0] d);
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    tick();
    ext_we = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [1:0] sh, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] d, input logic ui,
                          input logic [4:0] im, input logic wb, input logic sf,
                          input bit push, input exp_t e);
    if (push) sb.push_back(e);
    op = o; shift = sh; rn = a; rm = b; rd = d; use_imm = ui; imm = im;
    wb_en = wb; set_flags = sf; start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, output int lat);
    int k = 0;
    while (done !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    lat = cyc - start_cyc + 1;
    tick();
  endtask

  task automatic run_op(input logic [1:0] o, input logic [1:0] sh, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic ui,
                        input logic [4:0] im, input logic wb, input logic sf, input exp_t e);
    start_op(o, sh, a, b, d, ui, im, wb, sf, 1'b1, e);
    wait_done(e.tag, lat_last);
  endtask

  // AND with an all-ones immediate returns the register unchanged.
  task automatic rd_reg(input logic [2:0] idx, input logic [15:0] v, input string tag);
    run_op(2'd2, 2'd0, idx, 3'd0, 3'd0, 1'b1, 5'h1F, 1'b0, 1'b0,
           mk(v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag));
  endtask

  initial begin
    int b0;
    int d0;
    reset = 1'b1; start = 1'b0; op = '0; shift = '0; rn = '0; rm = '0; rd = '0;
    use_imm = 1'b0; imm = '0; wb_en = 1'b0; set_flags = 1'b0;
    ext_we = 1'b0; ext_waddr = '0; ext_wdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", datapath_out, 0);
    chk("rst_flags", {N, V, Z, C_flag}, 0);
    reset = 1'b0;
    tick();

    // Basic ADD with write-back, timing of busy/done.
    ext_wr(3'd1, 16'd5);
    ext_wr(3'd2, 16'd3);
    b0 = busy_cycles;
    run_op(2'd0, 2'd0, 3'd1, 3'd2, 3'd3, 1'b0, 5'd0, 1'b1, 1'b0,
           mk(16'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "add_5_3"));
    chk("add_latency", lat_last, 4);
    chk("add_busy_cycles", busy_cycles - b0, 4);
    chk("add_idle_after", busy, 0);
    rd_reg(3'd3, 16'd8, "rb_r3_wb");

    // SUB flags, then flags must hold across an op with set_flags low.
    run_op(2'd1, 2'd0, 3'd2, 3'd2, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1,
           mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, cf_exp(1'b1), "sub_3_3"));
    run_op(2'd2, 2'd0, 3'd1, 3'd0, 3'd0, 1'b1, 5'h1F, 1'b0, 1'b0,
           mk(16'h0005, 1'b1, 1'b0, 1'b0, 1'b1, cf_exp(1'b1), "flags_hold"));
    ext_wr(3'd4, 16'd1);
    run_op(2'd1, 2'd0, 3'd0, 3'd4, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1,
           mk(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, cf_exp(1'b0), "sub_0_1"));

    // ADD overflow and carry-out.
    ext_wr(3'd5, 16'h7FFF);
    run_op(2'd0, 2'd0, 3'd5, 3'd4, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1,
           mk(16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, cf_exp(1'b0), "add_ovf"));
    ext_wr(3'd6, 16'hFFFF);
    run_op(2'd0, 2'd0, 3'd6, 3'd4, 3'd0, 1'b0, 5'd0, 1'b0, 1'b1,
           mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, cf_exp(1'b1), "add_carry"));

    // Immediate, shifter and logic ops.
    run_op(2'd3, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 5'b11110, 1'b0, 1'b1,
           mk(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, cf_exp(1'b0), "mvn_imm"));
    ext_wr(3'd7, 16'h8004);
    run_op(2'd3, 2'd3, 3'd0, 3'd7, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0,
           mk(16'h3FFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mvn_asr"));
    run_op(2'd3, 2'd1, 3'd0, 3'd7, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0,
           mk(16'hFFF7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mvn_lsl"));
    run_op(2'd3, 2'd2, 3'd0, 3'd7, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0,
           mk(16'hBFFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mvn_lsr"));
    run_op(2'd2, 2'd1, 3'd6, 3'd0, 3'd0, 1'b1, 5'b01111, 1'b0, 1'b0,
           mk(16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "and_imm_noshift"));
    run_op(2'd0, 2'd0, 3'd3, 3'd3, 3'd3, 1'b0, 5'd0, 1'b1, 1'b0,
           mk(16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "add_rd_eq_src"));
    rd_reg(3'd3, 16'h0010, "rb_r3_self");

    // start, field changes and ext_we while busy are all ignored.
    d0 = done_cnt;
    start_op(2'd0, 2'd0, 3'd1, 3'd2, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             mk(16'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "busy_ignore"));
    start = 1'b1; op = 2'd3; rn = 3'd7; rm = 3'd7;
    ext_we = 1'b1; ext_waddr = 3'd2; ext_wdata = 16'h1234;
    tick(); tick();
    start = 1'b0; ext_we = 1'b0;
    wait_done("busy_ignore", lat_last);
    tick(); tick();
    chk("busy_ignore_idle", busy, 0);
    chk("busy_ignore_one_done", done_cnt - d0, 1);
    rd_reg(3'd2, 16'd3, "rb_r2_kept");

    // ext write in the same cycle as start feeds operand A.
    ext_we = 1'b1; ext_waddr = 3'd1; ext_wdata = 16'h00AA;
    start_op(2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
             mk(16'h00AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "same_cycle_ext"));
    ext_we = 1'b0;
    wait_done("same_cycle_ext", lat_last);

    // Reset during EXE aborts the operation with no write-back.
    d0 = done_cnt;
    start_op(2'd0, 2'd0, 3'd1, 3'd2, 3'd3, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0,
             mk(16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "abort"));
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", datapath_out, 0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    rd_reg(3'd3, 16'd0, "rb_r3_abort");
    rd_reg(3'd1, 16'd0, "rb_r1_cleared");
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
